// File: rtl/reg_select_encoder_p.sv
// Register select-and-encode unit.
// Holds a local copy of the instruction word and turns its Ra/Rb/Rc fields
// into one-hot register-file strobes under control-unit step signals.
// Also provides C-field extension, an R0-as-zero base-address read, a sticky
// multi-select error flag and a per-register write-pending scoreboard.
module reg_select_encoder_p #(
  parameter int REG_COUNT    = 16,
  parameter int SEL_BITS     = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 5,
  parameter int IMM_WIDTH    = 19
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic [DATA_WIDTH-1:0]   IRin,
  input  logic                    IRload,
  input  logic                    Gra,
  input  logic                    Grb,
  input  logic                    Grc,
  input  logic                    Rin,
  input  logic                    Rout,
  input  logic                    BAout,
  input  logic                    sext,
  input  logic                    sb_set,
  output logic [OPCODE_WIDTH-1:0] opcode,
  output logic [DATA_WIDTH-1:0]   C_ext,
  output logic [REG_COUNT-1:0]    RegIn,
  output logic [REG_COUNT-1:0]    RegOut,
  output logic                    ba_zero,
  output logic                    sel_error,
  output logic                    hazard
);

  // Field positions, packed downward from the opcode at the top of the word.
  localparam int RA_LSB = DATA_WIDTH - OPCODE_WIDTH - SEL_BITS;
  localparam int RB_LSB = RA_LSB - SEL_BITS;
  localparam int RC_LSB = RB_LSB - SEL_BITS;
  localparam int EXT_W  = DATA_WIDTH - IMM_WIDTH;

  logic [DATA_WIDTH-1:0] r_ir;
  logic [REG_COUNT-1:0]  r_pending;
  logic                  r_sel_error;

  logic [SEL_BITS-1:0]   w_ra;
  logic [SEL_BITS-1:0]   w_rb;
  logic [SEL_BITS-1:0]   w_rc;
  logic [SEL_BITS-1:0]   w_sel;
  logic                  w_any_gr;
  logic                  w_multi_gr;
  logic                  w_read_req;
  logic                  w_ba_zero;
  logic [REG_COUNT-1:0]  w_onehot;
  logic [REG_COUNT-1:0]  w_reg_in;
  logic [REG_COUNT-1:0]  w_reg_out;
  logic [IMM_WIDTH-1:0]  w_imm;
  logic                  w_ext_bit;
  logic [REG_COUNT-1:0]  w_pending_nxt;

  assign w_ra = r_ir[RA_LSB +: SEL_BITS];
  assign w_rb = r_ir[RB_LSB +: SEL_BITS];
  assign w_rc = r_ir[RC_LSB +: SEL_BITS];

  // Instruction latch: decode always works from the held copy, never from IRin.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_ir <= '0;
    end else if (IRload) begin
      r_ir <= IRin;
    end
  end

  // Field select with fixed Ra > Rb > Rc priority; fields are never merged.
  always_comb begin
    w_sel    = w_rc;
    w_any_gr = Gra | Grb | Grc;
    if (Gra) begin
      w_sel = w_ra;
    end else if (Grb) begin
      w_sel = w_rb;
    end
  end

  assign w_multi_gr = (Gra & Grb) | (Gra & Grc) | (Grb & Grc);
  assign w_onehot   = {{(REG_COUNT-1){1'b0}}, 1'b1} << w_sel;
  assign w_read_req = (Rout | BAout) & w_any_gr;

  // Base-address read of R0 reads as zero: suppress the strobe, tell the bus.
  assign w_ba_zero = BAout & ~Rout & w_any_gr & (w_sel == '0);

  // Strobe generation; nothing is driven without a field select.
  always_comb begin
    w_reg_in  = '0;
    w_reg_out = '0;
    if (Rin && w_any_gr) begin
      w_reg_in = w_onehot;
    end
    if (w_read_req && !w_ba_zero) begin
      w_reg_out = w_onehot;
    end
  end

  // C-field extension; sext picks sign fill versus zero fill.
  assign w_imm     = r_ir[IMM_WIDTH-1:0];
  assign w_ext_bit = sext & w_imm[IMM_WIDTH-1];
  assign C_ext     = {{EXT_W{w_ext_bit}}, w_imm};

  // Sticky multi-select flag; a new instruction clears it unless the same
  // edge sees another multi-select, in which case the error is kept.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_sel_error <= 1'b0;
    end else if (w_multi_gr) begin
      r_sel_error <= 1'b1;
    end else if (IRload) begin
      r_sel_error <= 1'b0;
    end
  end

  // Scoreboard next state: a write retires its register, then a new mark on
  // Ra is applied last so that a same-register set beats the clear.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_reg_in != '0) begin
      w_pending_nxt[w_sel] = 1'b0;
    end
    if (sb_set) begin
      w_pending_nxt[w_ra] = 1'b1;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign opcode    = r_ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign RegIn     = w_reg_in;
  assign RegOut    = w_reg_out;
  assign ba_zero   = w_ba_zero;
  assign sel_error = r_sel_error;
  // R0 on BAout never reads a real register, so it cannot be a hazard.
  assign hazard    = r_pending[w_sel] & w_read_req & ~w_ba_zero;

endmodule

// File: tb/tb_reg_select_encoder_p.sv
// Bench for reg_select_encoder_p: directed scenarios plus random traffic
// checked against a field-arithmetic reference model.
module tb_reg_select_encoder_p;

  logic        clock = 1'b0;
  logic        clear, IRload, Gra, Grb, Grc, Rin, Rout, BAout, sext, sb_set;
  logic [31:0] IRin;
  logic [4:0]  opcode;
  logic [31:0] C_ext;
  logic [15:0] RegIn, RegOut;
  logic        ba_zero, sel_error, hazard;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] mdl_ir;
  logic [15:0] mdl_pend;
  logic        mdl_err;

  reg_select_encoder_p dut (
    .clock(clock), .clear(clear), .IRin(IRin), .IRload(IRload),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .sext(sext), .sb_set(sb_set), .opcode(opcode), .C_ext(C_ext),
    .RegIn(RegIn), .RegOut(RegOut), .ba_zero(ba_zero),
    .sel_error(sel_error), .hazard(hazard)
  );

  always #5 clock = ~clock;

  // Expected combinational outputs from the model and the current inputs.
  task automatic model_outputs(output int sel, output logic [15:0] e_in,
                               output logic [15:0] e_out, output logic e_baz,
                               output logic e_haz, output logic [31:0] e_c);
    int ra, rb, rc, imm;
    bit any_gr, rd;
    ra = int'((mdl_ir >> 23) % 16);
    rb = int'((mdl_ir >> 19) % 16);
    rc = int'((mdl_ir >> 15) % 16);
    any_gr = Gra || Grb || Grc;
    sel = Gra ? ra : (Grb ? rb : rc);
    rd = (Rout || BAout) && any_gr;
    e_baz = BAout && !Rout && any_gr && sel == 0;
    e_in  = (Rin && any_gr) ? 16'(1 << sel) : 16'h0;
    e_out = (rd && !e_baz) ? 16'(1 << sel) : 16'h0;
    e_haz = mdl_pend[sel] && rd && !e_baz;
    imm = int'(mdl_ir % (1 << 19));
    if (sext && imm >= (1 << 18)) e_c = 32'(imm) + 32'hFFF8_0000;
    else e_c = 32'(imm);
  endtask

  // One clock edge, with the model advanced from the inputs present at it.
  task automatic tick();
    int sel, ra, ngr;
    logic [15:0] e_in, e_out;
    logic e_baz, e_haz;
    logic [31:0] e_c;
    @(posedge clock);
    model_outputs(sel, e_in, e_out, e_baz, e_haz, e_c);
    ra  = int'((mdl_ir >> 23) % 16);
    ngr = int'(Gra) + int'(Grb) + int'(Grc);
    if (clear) begin
      mdl_ir = 0; mdl_pend = 0; mdl_err = 0;
    end else begin
      if (ngr >= 2) mdl_err = 1;
      else if (IRload) mdl_err = 0;
      if (e_in != 0) mdl_pend[sel] = 1'b0;
      if (sb_set) mdl_pend[ra] = 1'b1;
      if (IRload) mdl_ir = IRin;
    end
    #1;
  endtask

  task automatic drive(input logic ld, input logic [31:0] ir, input logic a,
                       input logic b, input logic c, input logic wi,
                       input logic ro, input logic ba, input logic sx,
                       input logic sb);
    clear = 0; IRload = ld; IRin = ir; Gra = a; Grb = b; Grc = c;
    Rin = wi; Rout = ro; BAout = ba; sext = sx; sb_set = sb;
    #1;
  endtask

  task automatic load(input logic [31:0] ir);
    drive(1, ir, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    clear = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    clear = 1;
    tick(); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (opcode !== 5'd0 || C_ext !== 32'd0 || sel_error !== 1'b0 ||
        RegIn !== 16'd0 || RegOut !== 16'd0 || hazard !== 1'b0 || ba_zero !== 1'b0) begin
      n_err++;
      $display("FAIL reset: opcode=%0h C_ext=%0h sel_error=%0b RegIn=%0h RegOut=%0h hazard=%0b ba_zero=%0b, required all zero",
               opcode, C_ext, sel_error, RegIn, RegOut, hazard, ba_zero);
    end
  endtask

  task automatic test_decode();
    load(32'h1A93_8000);
    n_vec++;
    if (opcode !== 5'd3) begin n_err++; $display("FAIL decode_opcode: got %0d required 3", opcode); end
    drive(0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    n_vec++;
    if (RegOut !== 16'h0020) begin n_err++; $display("FAIL decode_ra_out: got %h required 0020", RegOut); end
    drive(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    n_vec++;
    if (RegIn !== 16'h0004 || RegOut !== 16'h0) begin
      n_err++; $display("FAIL decode_rb_in: RegIn=%h RegOut=%h required 0004/0000", RegIn, RegOut);
    end
    drive(0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    n_vec++;
    if (RegOut !== 16'h0080) begin n_err++; $display("FAIL decode_rc_out: got %h required 0080", RegOut); end
    n_vec++;
    if (sel_error !== 1'b0) begin n_err++; $display("FAIL decode_sel_error: got %0b required 0", sel_error); end
    // IRin changing without IRload must not disturb the decode
    drive(0, 32'hFFFF_FFFF, 1, 0, 0, 0, 1, 0, 0, 0);
    tick();
    n_vec++;
    if (RegOut !== 16'h0020 || opcode !== 5'd3) begin
      n_err++; $display("FAIL decode_hold: RegOut=%h opcode=%0d required 0020/3", RegOut, opcode);
    end
  endtask

  task automatic test_extension();
    load(32'h0007_FFFF);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    n_vec++;
    if (C_ext !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL ext_sign: got %h required ffffffff", C_ext); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (C_ext !== 32'h0007_FFFF) begin n_err++; $display("FAIL ext_zero: got %h required 0007ffff", C_ext); end
    load(32'h0000_0005);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    n_vec++;
    if (C_ext !== 32'h0000_0005) begin n_err++; $display("FAIL ext_pos: got %h required 00000005", C_ext); end
  endtask

  task automatic test_ba_zero();
    load(32'h1813_8000);
    drive(0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    n_vec++;
    if (RegOut !== 16'h0 || ba_zero !== 1'b1) begin
      n_err++; $display("FAIL ba_r0: RegOut=%h ba_zero=%0b required 0000/1", RegOut, ba_zero);
    end
    drive(0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    n_vec++;
    if (RegOut !== 16'h0001 || ba_zero !== 1'b0) begin
      n_err++; $display("FAIL rout_r0: RegOut=%h ba_zero=%0b required 0001/0", RegOut, ba_zero);
    end
    drive(0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    n_vec++;
    if (RegOut !== 16'h0004 || ba_zero !== 1'b0) begin
      n_err++; $display("FAIL ba_rb: RegOut=%h ba_zero=%0b required 0004/0", RegOut, ba_zero);
    end
  endtask

  task automatic test_multi_select();
    load(32'h1A93_8000);
    drive(0, 0, 1, 1, 0, 0, 1, 0, 0, 0);
    n_vec++;
    if (RegOut !== 16'h0020 || sel_error !== 1'b0) begin
      n_err++; $display("FAIL multi_prio: RegOut=%h sel_error=%0b required 0020/0", RegOut, sel_error);
    end
    tick();
    drive(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    n_vec++;
    if (sel_error !== 1'b1) begin n_err++; $display("FAIL multi_set: got %0b required 1", sel_error); end
    tick(); tick();
    n_vec++;
    if (sel_error !== 1'b1) begin n_err++; $display("FAIL multi_sticky: got %0b required 1", sel_error); end
    load(32'h1A93_8000);
    n_vec++;
    if (sel_error !== 1'b0) begin n_err++; $display("FAIL multi_clear_load: got %0b required 0", sel_error); end
    drive(1, 32'h1A93_8000, 0, 1, 1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (sel_error !== 1'b1) begin n_err++; $display("FAIL multi_vs_load: got %0b required 1", sel_error); end
    load(32'h1A93_8000);
  endtask

  task automatic test_scoreboard();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    n_vec++;
    if (hazard !== 1'b1) begin n_err++; $display("FAIL sb_ra_hazard: got %0b required 1", hazard); end
    drive(0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    n_vec++;
    if (hazard !== 1'b1) begin n_err++; $display("FAIL sb_ra_ba_hazard: got %0b required 1", hazard); end
    drive(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    n_vec++;
    if (hazard !== 1'b0) begin n_err++; $display("FAIL sb_rb_hazard: got %0b required 0", hazard); end
    drive(0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    n_vec++;
    if (hazard !== 1'b0) begin n_err++; $display("FAIL sb_write_clears: got %0b required 0", hazard); end
    drive(0, 0, 1, 0, 0, 1, 0, 0, 0, 1);
    tick();
    drive(0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    n_vec++;
    if (hazard !== 1'b1) begin n_err++; $display("FAIL sb_set_wins: got %0b required 1", hazard); end
  endtask

  task automatic test_clear_mid();
    // pending[5] is set from the scoreboard test and IR_q holds 0x1A938000
    drive(1, 32'h1A93_8000, 1, 1, 0, 0, 0, 0, 0, 1);
    clear = 1;
    tick();
    drive(0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    n_vec++;
    if (opcode !== 5'd0 || sel_error !== 1'b0 || hazard !== 1'b0 || RegOut !== 16'h0001) begin
      n_err++; $display("FAIL clear_mid: opcode=%0d sel_error=%0b hazard=%0b RegOut=%h required 0/0/0/0001",
                        opcode, sel_error, hazard, RegOut);
    end
    load(32'h1A93_8000);
    drive(0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    n_vec++;
    if (hazard !== 1'b0) begin n_err++; $display("FAIL clear_pending: got %0b required 0", hazard); end
  endtask

  task automatic test_random();
    int sel;
    logic [15:0] e_in, e_out;
    logic e_baz, e_haz;
    logic [31:0] e_c;
    for (int i = 0; i < 400; i++) begin
      clear  = ($urandom_range(0, 39) == 0);
      IRload = ($urandom_range(0, 3) == 0);
      IRin   = $urandom;
      Gra = $urandom_range(0, 1); Grb = $urandom_range(0, 1); Grc = $urandom_range(0, 1);
      if ($urandom_range(0, 3) != 0) begin
        if (Gra) begin Grb = 0; Grc = 0; end else if (Grb) Grc = 0;
      end
      Rin = $urandom_range(0, 1); Rout = $urandom_range(0, 1); BAout = $urandom_range(0, 1);
      sext = $urandom_range(0, 1); sb_set = ($urandom_range(0, 2) == 0);
      #1;
      model_outputs(sel, e_in, e_out, e_baz, e_haz, e_c);
      n_vec++;
      if (RegIn !== e_in || RegOut !== e_out || ba_zero !== e_baz || hazard !== e_haz ||
          C_ext !== e_c || opcode !== mdl_ir[31:27] || sel_error !== mdl_err) begin
        n_err++;
        $display("FAIL random[%0d]: RegIn=%h/%h RegOut=%h/%h ba_zero=%0b/%0b hazard=%0b/%0b C_ext=%h/%h opcode=%0d/%0d sel_error=%0b/%0b (actual/required)",
                 i, RegIn, e_in, RegOut, e_out, ba_zero, e_baz, hazard, e_haz,
                 C_ext, e_c, opcode, mdl_ir[31:27], sel_error, mdl_err);
      end
      tick();
    end
  endtask

  initial begin
    mdl_ir = 0; mdl_pend = 0; mdl_err = 0;
    test_reset();
    test_decode();
    test_extension();
    test_ba_zero();
    test_multi_select();
    test_scoreboard();
    test_clear_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_select_encoder_p.md
Name: reg_select_encoder_p

Overview:
Parametrised next-generation select-and-encode unit for the register-file datapath.
- Latches the instruction word locally and decodes the Ra/Rb/Rc fields into one-hot register-file in/out strobes.
- Adds R0-reads-as-zero on BAout, configurable sign/zero extension of the C field, sticky multi-select error detection, and a per-register write-pending scoreboard for hazard checks.
- Sits between the IR and the register file / bus multiplexer, driven by the control unit step by step.

Parameters:
- REG_COUNT, 16, number of general registers (power of two, 2..32).
- SEL_BITS, 4, register-field width; must equal log2(REG_COUNT).
- DATA_WIDTH, 32, instruction and C_ext width.
- OPCODE_WIDTH, 5, opcode field width (MSBs of IR).
- IMM_WIDTH, 19, C field width (IR[IMM_WIDTH-1:0]).

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  synchronous active-high reset
- IRin  in  DATA_WIDTH  instruction word from bus
- IRload  in  1  latch IRin into internal IR_q
- Gra, Grb, Grc  in  1 each  field select
- Rin, Rout, BAout  in  1 each  register write / read / base-address read
- sext  in  1  1 = sign-extend C, 0 = zero-extend
- sb_set  in  1  mark register in IR_q Ra field as write-pending
- opcode  out  OPCODE_WIDTH  IR_q opcode field
- C_ext  out  DATA_WIDTH  extended C field
- RegIn  out  REG_COUNT  one-hot write strobes
- RegOut  out  REG_COUNT  one-hot read strobes
- ba_zero  out  1  bus must drive zero (BAout on R0)
- sel_error  out  1  sticky: more than one Gr* asserted
- hazard  out  1  currently selected read register is write-pending

Behaviour:
- Clock is `clock`. Reset is `clear`, synchronous and active-high. On a `clock` edge with `clear`=1: IR_q=0, pending=0, sel_error=0. `clear` has priority over all other inputs.
- Field layout:
  - opcode = IR_q[DATA_WIDTH-1 -: OPCODE_WIDTH]
  - Ra = next SEL_BITS down, then Rb, then Rc
  - Defaults: opcode 31:27, Ra 26:23, Rb 22:19, Rc 18:15.
- IR_q loads IRin on the `clock` edge with IRload=1, otherwise holds. All decode uses IR_q, never IRin. New fields are visible the cycle after the load edge.
- Selection (combinational from IR_q and Gr*): sel = Ra if Gra, else Rb if Grb, else Rc if Grc. Priority is Ra>Rb>Rc; fields are never ORed. If no Gr* is asserted, no strobe is driven.
- RegIn = onehot(sel) when Rin and some Gr* is asserted, else 0.
- RegOut:
  - RegOut = onehot(sel) when (Rout | BAout) and some Gr* is asserted, else 0.
  - Exception: BAout=1, Rout=0, sel=0 → RegOut=0 and ba_zero=1.
  - ba_zero=0 in all other cases.
- C_ext = IR_q[IMM_WIDTH-1:0] extended to DATA_WIDTH. sext=1 replicates bit IMM_WIDTH-1; sext=0 fills with 0. Purely combinational.
- sel_error:
  - Set on a `clock` edge when two or more of Gra/Grb/Grc are 1.
  - Cleared only by `clear` or by an IRload edge.
  - If IRload and a multi-select occur on the same edge, the set wins (sel_error=1).
- Scoreboard `pending` (REG_COUNT bits), updated on the `clock` edge:
  - sb_set=1 sets pending[Ra of IR_q].
  - A write (RegIn nonzero) clears pending[sel].
  - Same register set and cleared on the same edge → set wins.
  - Different registers are updated independently.
- hazard = pending[sel] & (Rout | BAout) & (some Gr*), combinational. Exception: BAout on R0 gives hazard=0.
- Reset mid-operation discards pending marks and the latched IR. The outputs reflect IR_q=0 on the next cycle.

Test Plan:
1. Decode and read: load IRin=0x1A938000 → opcode=3. Gra+Rout → RegOut=0x0020. Grb+Rin → RegIn=0x0004. Grc+Rout → RegOut=0x0080. sel_error=0.
2. Extension: load IRin=0x0007FFFF. sext=1 → C_ext=0xFFFFFFFF; sext=0 → C_ext=0x0007FFFF. Load IRin=0x00000005, sext=1 → C_ext=0x00000005.
3. BAout on R0: IR_q Ra=0, Gra+BAout → RegOut=0x0000, ba_zero=1. Gra+Rout → RegOut=0x0001, ba_zero=0.
4. Multi-select: Gra+Grb+Rout with IR 0x1A938000 → RegOut=0x0020 (Ra priority). sel_error=1 next cycle and stays 1. The next IRload edge without multi-select → sel_error=0.
5. Scoreboard with IR 0x1A938000:
   - sb_set edge → Gra+Rout gives hazard=1; Grb+Rout gives hazard=0.
   - Gra+Rin edge → Gra+Rout hazard=0.
   - sb_set together with Gra+Rin on one edge → hazard remains 1.
6. Reset: with pending[5]=1 and IR_q loaded, assert `clear` for one edge → opcode=0, pending=0, sel_error=0, hazard=0. A `clear` asserted on the same edge as IRload leaves IR_q=0.
